tdm_demux8: RTL and testbench
=============================

# tdm_demux8

Eight-slot time-division demultiplexer: the receive end of the 8:1 mux path. Takes one W-bit lane carrying slots 0..7 in order, marked by a frame-sync strobe on slot 0. Captures each slot into a shadow register and publishes all eight lanes in parallel, with a one-cycle valid pulse, once a frame completes. Sits after the serializing mux8 stage, or after a link, to recover the original D0..D7 lanes.

## Interface
- W, default 1: width of each lane/slot in bits.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample strobe; a slot is consumed only on cycles with en=1.
- din  in  W  serialized slot data.
- frame_sync  in  1  qualified by en; marks din as slot 0.
- Y0..Y7  out  W each  registered demuxed lanes, updated atomically per frame.
- frame_valid  out  1  one-cycle pulse: Y0..Y7 were just updated.
- sync_err  out  1  one-cycle pulse: framing violation detected.
- locked  out  1  high in LOCKED state.
- slot  out  3  index of the next slot expected.

## Operation
- States: HUNT, LOCKED.
- HUNT:
  - Ignore din until en=1 and frame_sync=1.
  - On that cycle, capture din into shadow[0], set slot=1, go to LOCKED.
- LOCKED, each en=1 cycle with slot=s:
  - If frame_sync=1 and s≠0: pulse sync_err, discard the partial frame, capture din into shadow[0], set slot=1. Stay LOCKED.
  - Otherwise capture din into shadow[s], then slot = s+1 mod 8.
  - When s=7: load Y0..Y6 from shadow[0..6] and Y7 from din on the same edge, and pulse frame_valid.
  - slot wraps 7→0.
- Missing frame_sync at s=0 in LOCKED: behaviour set by the macro in Configuration.
- en=0: no capture, slot holds, state holds. frame_sync is ignored.
- Y0..Y7 change only on frame completion. A partial or discarded frame never reaches Y.
- Shadow registers need no reset. Every Y bit comes from a slot written in the current frame.

## Timing
- Reset values: Y0..Y7=0, frame_valid=0, sync_err=0, locked=0, slot=0, state=HUNT.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.
- After rst deasserts, the first capture can happen on the first rising edge.
- Latency: Y and frame_valid are valid the cycle after the edge that samples slot 7.
  - Back-to-back frames with en=1 continuously give frame_valid once every 8 cycles.
- frame_valid and sync_err are registered pulses, exactly one cycle wide.
- locked rises the cycle after the HUNT capture edge.
- Simultaneous frame_sync at s=7: resync takes priority. sync_err=1, frame_valid=0, Y unchanged.

## Configuration
- TDM_DEMUX_STRICT_SYNC_EN defined:
  - In LOCKED, en=1 at slot=0 with frame_sync=0 pulses sync_err and returns to HUNT with locked=0.
  - Nothing is captured on that cycle.
- Not defined (flywheel):
  - frame_sync is optional at slot 0. Capture proceeds from slot position alone.
  - Only an early frame_sync (s≠0) raises sync_err.

## Test plan
- Basic frame, W=1:
  - Stimulus: after reset, en=1 continuously; frame_sync on the first cycle; din = 1,0,1,1,0,0,1,0 for slots 0..7.
  - Response: Y0..Y7 = 1,0,1,1,0,0,1,0, frame_valid high for one cycle, locked=1, slot=0.
- Gapped enable, W=4:
  - Stimulus: en toggles 1,0 each cycle; slots carry 4'h0..4'h7.
  - Response: Y0..Y7 = 0..7, frame_valid after 15 cycles, slot holds on en=0 cycles.
- Early sync:
  - Stimulus: LOCKED, frame_sync at slot 4 with din=4'hA.
  - Response: sync_err pulse, Y unchanged, shadow[0]=A, slot=1; the next full frame publishes correctly.
- Missing sync at slot 0:
  - Stimulus: LOCKED, frame_sync=0 at slot 0.
  - Response with TDM_DEMUX_STRICT_SYNC_EN: sync_err pulse, locked=0, no frame_valid until the next sync plus 8 slots.
  - Response without the macro: frame completes normally, no sync_err.
- Reset mid-frame:
  - Stimulus: rst pulsed at slot 5.
  - Response: all outputs 0 asynchronously, state HUNT; a following sync-aligned frame publishes correctly.
- Sync on slot 7 collision:
  - Stimulus: frame_sync at s=7.
  - Response: sync_err=1, frame_valid=0, Y keeps the previous frame's values.

Source files
------------

// File: rtl/tdm_demux8.sv
// Eight-slot TDM demultiplexer: recovers lanes Y0..Y7 from one serialized lane framed by frame_sync.
// Define TDM_DEMUX_STRICT_SYNC_EN to require frame_sync at every slot 0 (otherwise flywheel framing).
module tdm_demux8 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  input  logic         frame_sync,
  output logic [W-1:0] Y0,
  output logic [W-1:0] Y1,
  output logic [W-1:0] Y2,
  output logic [W-1:0] Y3,
  output logic [W-1:0] Y4,
  output logic [W-1:0] Y5,
  output logic [W-1:0] Y6,
  output logic [W-1:0] Y7,
  output logic         frame_valid,
  output logic         sync_err,
  output logic         locked,
  output logic [2:0]   slot
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [2:0]   slot_q, slot_d;
  logic         frame_valid_q, frame_valid_d;
  logic         sync_err_q, sync_err_d;
  logic [W-1:0] y_q [8];
  logic [W-1:0] shadow_q [8];
  logic         shadow_we;
  logic [2:0]   shadow_idx;
  logic         y_load;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    shadow_we     = 1'b0;
    shadow_idx    = slot_q;
    y_load        = 1'b0;
    case (state_q)
      HUNT: begin
        if (en && frame_sync) begin
          shadow_we  = 1'b1;
          shadow_idx = 3'd0;
          slot_d     = 3'd1;
          state_d    = LOCKED;
        end else begin
          slot_d = 3'd0;
        end
      end
      LOCKED: begin
        if (!en) begin
          slot_d = slot_q;
        end else if (frame_sync && (slot_q != 3'd0)) begin
          // Early sync wins over completion at slot 7: restart the frame, Y stays put.
          sync_err_d = 1'b1;
          shadow_we  = 1'b1;
          shadow_idx = 3'd0;
          slot_d     = 3'd1;
`ifdef TDM_DEMUX_STRICT_SYNC_EN
        end else if (!frame_sync && (slot_q == 3'd0)) begin
          sync_err_d = 1'b1;
          slot_d     = 3'd0;
          state_d    = HUNT;
`endif
        end else begin
          shadow_we = 1'b1;
          slot_d    = slot_q + 3'd1;
          if (slot_q == 3'd7) begin
            y_load        = 1'b1;
            frame_valid_d = 1'b1;
          end else begin
            y_load = 1'b0;
          end
        end
      end
      default: begin
        state_d = HUNT;
        slot_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_q        <= 3'd0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      for (int i = 0; i < 8; i++) y_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      if (y_load) begin
        for (int i = 0; i < 7; i++) y_q[i] <= shadow_q[i];
        y_q[7] <= din;
      end
    end
  end

  // Shadow storage carries no reset: Y only ever loads slots written in the current frame.
  always_ff @(posedge clk) begin
    if (shadow_we) shadow_q[shadow_idx] <= din;
  end

  assign Y0          = y_q[0];
  assign Y1          = y_q[1];
  assign Y2          = y_q[2];
  assign Y3          = y_q[3];
  assign Y4          = y_q[4];
  assign Y5          = y_q[5];
  assign Y6          = y_q[6];
  assign Y7          = y_q[7];
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCKED);
  assign slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed self-checking bench for tdm_demux8 (W=4), lanes compared as one packed word {Y0..Y7}.
module tb_tdm_demux8;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [W-1:0] din = '0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
  logic         frame_valid, sync_err, locked;
  logic [2:0]   slot;
  int           n_checks = 0;
  int           n_errors = 0;

  tdm_demux8 #(.W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .frame_sync(frame_sync),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4), .Y5(Y5), .Y6(Y6), .Y7(Y7),
    .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked), .slot(slot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic fs, input logic [W-1:0] d);
    en = e;
    frame_sync = fs;
    din = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ybus();
    return {Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7};
  endfunction

  logic [W-1:0] basic [8];

  initial begin
    basic = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0};
    #12;
    check("rst_y", ybus(), 32'h0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_slot", {29'd0, slot}, 32'd0);
    check("rst_pulses", {30'd0, frame_valid, sync_err}, 32'd0);
    rst = 1'b0;

    // basic frame
    step(1'b1, 1'b1, basic[0]);
    check("hunt_lock", {28'd0, locked, slot}, {28'd0, 1'b1, 3'd1});
    for (int s = 1; s < 7; s++) step(1'b1, 1'b0, basic[s]);
    check("basic_pre_fv", {31'd0, frame_valid}, 32'd0);
    step(1'b1, 1'b0, basic[7]);
    check("basic_fv", {31'd0, frame_valid}, 32'd1);
    check("basic_y", ybus(), 32'h1011_0010);
    check("basic_slot_locked", {28'd0, locked, slot}, {28'd0, 1'b1, 3'd0});
    step(1'b0, 1'b0, 4'hF);
    check("basic_fv_one_cycle", {31'd0, frame_valid}, 32'd0);

    // gapped enable, sync on slot 0 while locked
    for (int s = 0; s < 8; s++) begin
      step(1'b1, (s == 0), s[3:0]);
      if (s < 7) begin
        step(1'b0, 1'b1, 4'hF);
        check("gap_slot_hold", {29'd0, slot}, {29'd0, 3'(s + 1)});
        check("gap_no_fv", {31'd0, frame_valid}, 32'd0);
      end
    end
    check("gap_fv", {31'd0, frame_valid}, 32'd1);
    check("gap_y", ybus(), 32'h0123_4567);

    // early sync at slot 4
    for (int s = 0; s < 4; s++) step(1'b1, (s == 0), 4'h8 + 4'(s));
    step(1'b1, 1'b1, 4'hA);
    check("early_err", {30'd0, sync_err, frame_valid}, 32'd2);
    check("early_y_kept", ybus(), 32'h0123_4567);
    check("early_slot", {29'd0, slot}, 32'd1);
    for (int s = 1; s < 8; s++) step(1'b1, 1'b0, s[3:0]);
    check("early_fv", {31'd0, frame_valid}, 32'd1);
    check("early_y", ybus(), 32'hA123_4567);
    check("early_err_one_cycle", {31'd0, sync_err}, 32'd0);

    // missing sync at slot 0
    step(1'b1, 1'b0, 4'h5);
`ifdef TDM_DEMUX_STRICT_SYNC_EN
    check("miss_err", {31'd0, sync_err}, 32'd1);
    check("miss_unlock", {28'd0, locked, slot}, 32'd0);
    for (int s = 1; s < 8; s++) step(1'b1, 1'b0, s[3:0]);
    check("miss_no_fv", {30'd0, frame_valid, locked}, 32'd0);
    check("miss_y_kept", ybus(), 32'hA123_4567);
`else
    check("miss_no_err", {31'd0, sync_err}, 32'd0);
    check("miss_slot", {28'd0, locked, slot}, {28'd0, 1'b1, 3'd1});
    for (int s = 1; s < 8; s++) step(1'b1, 1'b0, s[3:0]);
    check("miss_fv", {30'd0, frame_valid, sync_err}, 32'd2);
    check("miss_y", ybus(), 32'h5123_4567);
`endif

    // reset mid-frame at slot 5
    for (int s = 0; s < 5; s++) step(1'b1, (s == 0), 4'h9);
    check("pre_rst_slot", {29'd0, slot}, 32'd5);
    rst = 1'b1;
    #1;
    check("async_rst_y", ybus(), 32'h0);
    check("async_rst_state", {27'd0, locked, slot, frame_valid, sync_err}, 32'd0);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 4'h3);
    check("post_rst_hunt", {31'd0, locked}, 32'd0);
    step(1'b1, 1'b1, 4'hC);
    step(1'b1, 1'b0, 4'hD);
    step(1'b1, 1'b0, 4'hE);
    step(1'b1, 1'b0, 4'hF);
    for (int s = 4; s < 8; s++) step(1'b1, 1'b0, 4'(s - 4));
    check("post_rst_fv", {31'd0, frame_valid}, 32'd1);
    check("post_rst_y", ybus(), 32'hCDEF_0123);

    // sync collision at slot 7
    for (int s = 0; s < 7; s++) step(1'b1, (s == 0), 4'h4);
    step(1'b1, 1'b1, 4'h9);
    check("coll_flags", {30'd0, sync_err, frame_valid}, 32'd2);
    check("coll_y_kept", ybus(), 32'hCDEF_0123);
    check("coll_slot", {29'd0, slot}, 32'd1);
    for (int s = 1; s < 8; s++) step(1'b1, 1'b0, 4'hF - 4'(s));
    check("coll_fv", {31'd0, frame_valid}, 32'd1);
    check("coll_y", ybus(), 32'h9EDC_BA98);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
